tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency; the period table in REQ-013 is for this value.
REQ-002 Parameter N_STABLE, default 3, consecutive matching periods required to lock a note.
REQ-003 Parameter TIMEOUT, default 524288, idle cycles after which the input is declared silent.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-006 en  input  1  decoder enable, synchronous to clk.
REQ-007 tone_in  input  1  asynchronous square-wave tone, as driven onto the bell line.
REQ-008 note  output  4  locked note index: 0 none, 1..8 = C4 D4 E4 F4 G4 A4 B4 C5.
REQ-009 valid  output  1  high while note holds a locked value.
REQ-010 note_strobe  output  1  one-cycle pulse when note changes to a new non-zero value.
REQ-011 LED  output  16  LED[note-1] high when valid, all others low; 16'h0000 when not valid.
REQ-012 period  output  20  last measured period in clk cycles, for debug.

Function
REQ-013 Nominal periods P[1..8] SHALL be 382219, 340530, 303370, 286344, 255102, 227273, 202478, 191113 cycles.
REQ-014 tone_in SHALL pass a 2-flop synchronizer and then a rising-edge detector that produces a one-cycle edge pulse.
REQ-015 Measured period SHALL be the cycle distance between consecutive edge pulses: counter set to 1 on an edge, incremented on every other cycle, sampled into period on the next edge.
REQ-016 Classification: index k matches when |period - P[k]| <= (P[k] >> 6), using unsigned 20-bit arithmetic with no wrap; no match gives class 0; if several indices match, the lowest index wins.
REQ-017 FSM states: IDLE, MEAS.
- IDLE: counter held at 0; the first edge moves to MEAS.
- MEAS: counts and classifies on each edge; counter reaching TIMEOUT moves to IDLE.
REQ-018 Candidate tracking on each MEAS edge:
- class == cand and nonzero: match_cnt increments, saturating at N_STABLE.
- otherwise: cand <= class; match_cnt <= 1 if class is nonzero, else 0.
REQ-019 When match_cnt reaches N_STABLE, note <= cand and valid <= 1 in the cycle after that edge is registered.
REQ-020 note_strobe SHALL pulse in that same cycle only if the new note differs from the previous note or valid was low.
REQ-021 A class-0 period SHALL clear valid, note and LED in the cycle after the edge.
REQ-022 A timeout SHALL clear valid, note, LED, cand and match_cnt; period holds its last value.
REQ-023 en low SHALL force IDLE, clear valid, note, LED, cand and match_cnt, and suppress note_strobe; measurement restarts from the first edge after en rises.
REQ-024 An edge pulse in the same cycle as a timeout SHALL take priority: it is classified and the FSM stays in MEAS.
REQ-025 The counter SHALL saturate at TIMEOUT and never wrap.
REQ-026 note, valid, note_strobe and LED SHALL be registered outputs.

Reset
REQ-027 rst high SHALL immediately clear the FSM (to IDLE), synchronizer, counter, cand, match_cnt, note, valid, note_strobe, LED and period to 0.
REQ-028 Deasserting rst SHALL NOT by itself create an edge pulse, even with tone_in high.

Verification
REQ-029 A4 square wave (period 227273), 8 cycles -> valid rises after the 4th rising edge; note=6, LED=16'h0020, exactly one note_strobe.
REQ-030 Periods of 230824 and then 230825 -> 230824 classifies as A4; 230825 classifies as 0 and valid drops.
REQ-031 Locked A4 switched on an edge to B4 (202478) -> valid drops on the first B4 edge, then relocks after N_STABLE B4 periods; note=7, LED=16'h0040, one strobe.
REQ-032 Locked C4, input then held low -> TIMEOUT cycles after the last edge: valid=0, note=0, LED=0, period=382219.
REQ-033 Locked G4, rst pulsed mid-period -> all outputs 0 asynchronously; relock after 4 further edges.
REQ-034 en low while the A4 tone runs -> valid stays 0 and no strobe; after en rises, lock after 4 edges.

Source files
------------

// File: rtl/tone_decoder_if.sv
// Port bundle for the bell-line tone decoder: enable and raw tone in, locked-note status out.
interface tone_decoder_if;
  logic        en;
  logic        tone_in;
  logic [3:0]  note;
  logic        valid;
  logic        note_strobe;
  logic [15:0] LED;
  logic [19:0] period;

  modport master (output en, tone_in, input note, valid, note_strobe, LED, period);
  modport slave  (input en, tone_in, output note, valid, note_strobe, LED, period);
endinterface

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone between rising edges, classifies it
// against the C4..C5 scale and locks a note after N_STABLE consecutive matches.
module tone_decoder #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned N_STABLE = 3,
  parameter int unsigned TIMEOUT  = 524288
) (
  input logic           clk,
  input logic           rst,
  tone_decoder_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_e;

  localparam int unsigned   MW = $clog2(N_STABLE + 1);
  localparam logic [MW-1:0] NS = MW'(N_STABLE);
  localparam logic [19:0]   TO = 20'(TIMEOUT);

  // Note frequencies in centi-Hz; periods are rounded to the nearest clock, which
  // reproduces 382219..191113 exactly at 100 MHz.
  function automatic logic [19:0] nom_period(input int idx);
    longint unsigned f, c;
    case (idx)
      0:       f = 64'd26163;
      1:       f = 64'd29366;
      2:       f = 64'd32963;
      3:       f = 64'd34923;
      4:       f = 64'd39200;
      5:       f = 64'd44000;
      6:       f = 64'd49388;
      default: f = 64'd52325;
    endcase
    c = (64'(CLK_HZ) * 64'd100 + f / 64'd2) / f;
    return c[19:0];
  endfunction

  localparam logic [19:0] P [8] = '{nom_period(0), nom_period(1), nom_period(2), nom_period(3),
                                    nom_period(4), nom_period(5), nom_period(6), nom_period(7)};

  state_e         state_q, state_d;
  logic [2:0]     sync_q, sync_d;
  logic [1:0]     fill_q, fill_d;
  logic [19:0]    cnt_q, cnt_d;
  logic [3:0]     cand_q, cand_d;
  logic [MW-1:0]  mcnt_q, mcnt_d, mcnt_nx;
  logic [3:0]     note_q, note_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic [15:0]    led_q, led_d;
  logic [19:0]    period_q, period_d;
  logic           edge_p;
  logic [3:0]     cls;
  logic [19:0]    diff;

  // sync_q[2] is the edge history; fill_q keeps the post-reset zeros from
  // looking like a low-to-high transition while the pipe fills with real samples.
  always_comb begin
    sync_d = {sync_q[1:0], bus.tone_in};
    fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    edge_p = (fill_q == 2'd3) && sync_q[1] && !sync_q[2];
  end

  // Scan downward so the lowest matching index is the one that sticks.
  always_comb begin
    cls  = '0;
    diff = '0;
    for (int k = 7; k >= 0; k--) begin
      diff = (cnt_q >= P[3'(k)]) ? cnt_q - P[3'(k)] : P[3'(k)] - cnt_q;
      if (diff <= (P[3'(k)] >> 6)) cls = 4'(k + 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    mcnt_d   = mcnt_q;
    mcnt_nx  = '0;
    note_d   = note_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    led_d    = led_q;
    period_d = period_q;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      cand_d  = '0;
      mcnt_d  = '0;
      note_d  = '0;
      valid_d = 1'b0;
      led_d   = '0;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      if (edge_p) begin
        state_d = MEAS;
        cnt_d   = 20'd1;
      end
    end else if (edge_p) begin
      // An edge wins over a coincident timeout: classify and keep measuring.
      cnt_d    = 20'd1;
      period_d = cnt_q;
      if (cls != 4'd0 && cls == cand_q) mcnt_nx = (mcnt_q == NS) ? mcnt_q : mcnt_q + 1'b1;
      else                              mcnt_nx = (cls != 4'd0) ? MW'(1) : '0;
      cand_d = cls;
      mcnt_d = mcnt_nx;
      if (mcnt_nx == NS) begin
        note_d   = cls;
        valid_d  = 1'b1;
        led_d    = 16'(1) << (cls - 4'd1);
        strobe_d = !valid_q || (note_q != cls);
      end else begin
        note_d  = '0;
        valid_d = 1'b0;
        led_d   = '0;
      end
    end else if (cnt_q == TO) begin
      state_d = IDLE;
      cnt_d   = '0;
      cand_d  = '0;
      mcnt_d  = '0;
      note_d  = '0;
      valid_d = 1'b0;
      led_d   = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      cand_q   <= '0;
      mcnt_q   <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      led_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      mcnt_q   <= mcnt_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      led_q    <= led_d;
      period_q <= period_d;
    end
  end

  assign bus.note        = note_q;
  assign bus.valid       = valid_q;
  assign bus.note_strobe = strobe_q;
  assign bus.LED         = led_q;
  assign bus.period      = period_q;
endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder at a 200 kHz clock, where the scale periods become
// C4 764, D4 681, E4 607, F4 573, G4 510, A4 455, B4 405, C5 382 (tolerance P>>6).
module tb_tone_decoder;
  localparam int SETTLE = 8;
  localparam int TO     = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_decoder_if bus();

  tone_decoder #(.CLK_HZ(200000), .N_STABLE(3), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // p: cycles from the previous rising edge to the next one; expectations hold
  // SETTLE cycles after that next edge.
  typedef struct {
    int          p;
    logic [3:0]  note;
    logic        valid;
    logic [15:0] led;
    int          strb;
    logic [19:0] per;
  } vec_t;

  vec_t vt [39];
  int   n_vec = 0;
  int   n_err = 0;
  int   strobes = 0;
  int   strobes_seen = 0;

  always @(negedge clk) if (bus.note_strobe === 1'b1) strobes++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] n, input logic v, input logic [15:0] l);
    chk({nm, " note"},  32'(bus.note),  32'(n));
    chk({nm, " valid"}, 32'(bus.valid), 32'(v));
    chk({nm, " LED"},   32'(bus.LED),   32'(l));
  endtask

  task automatic apply(input int i);
    repeat (vt[i].p / 2 - SETTLE) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (vt[i].p - vt[i].p / 2) @(negedge clk);
    bus.tone_in = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk_out($sformatf("v%0d", i), vt[i].note, vt[i].valid, vt[i].led);
    chk($sformatf("v%0d period", i), 32'(bus.period), 32'(vt[i].per));
    chk($sformatf("v%0d strobes", i), 32'(strobes - strobes_seen), 32'(vt[i].strb));
    strobes_seen = strobes;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
  endtask

  initial begin
    // A4 lock, then held steady
    vt[0]  = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[1]  = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[2]  = '{455, 4'd6, 1'b1, 16'h0020, 1, 20'd455};
    vt[3]  = '{455, 4'd6, 1'b1, 16'h0020, 0, 20'd455};
    vt[4]  = '{455, 4'd6, 1'b1, 16'h0020, 0, 20'd455};
    vt[5]  = '{455, 4'd6, 1'b1, 16'h0020, 0, 20'd455};
    vt[6]  = '{455, 4'd6, 1'b1, 16'h0020, 0, 20'd455};
    // tolerance edges of the A4 window 448..462
    vt[7]  = '{462, 4'd6, 1'b1, 16'h0020, 0, 20'd462};
    vt[8]  = '{463, 4'd0, 1'b0, 16'h0000, 0, 20'd463};
    vt[9]  = '{448, 4'd0, 1'b0, 16'h0000, 0, 20'd448};
    vt[10] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[11] = '{455, 4'd6, 1'b1, 16'h0020, 1, 20'd455};
    vt[12] = '{447, 4'd0, 1'b0, 16'h0000, 0, 20'd447};
    // relock A4, then switch to B4
    vt[13] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[14] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[15] = '{455, 4'd6, 1'b1, 16'h0020, 1, 20'd455};
    vt[16] = '{405, 4'd0, 1'b0, 16'h0000, 0, 20'd405};
    vt[17] = '{405, 4'd0, 1'b0, 16'h0000, 0, 20'd405};
    vt[18] = '{405, 4'd7, 1'b1, 16'h0040, 1, 20'd405};
    // C5 window 377..387 across its limits
    vt[19] = '{387, 4'd0, 1'b0, 16'h0000, 0, 20'd387};
    vt[20] = '{377, 4'd0, 1'b0, 16'h0000, 0, 20'd377};
    vt[21] = '{382, 4'd8, 1'b1, 16'h0080, 1, 20'd382};
    vt[22] = '{388, 4'd0, 1'b0, 16'h0000, 0, 20'd388};
    // C4 window 753..775
    vt[23] = '{764, 4'd0, 1'b0, 16'h0000, 0, 20'd764};
    vt[24] = '{775, 4'd0, 1'b0, 16'h0000, 0, 20'd775};
    vt[25] = '{753, 4'd1, 1'b1, 16'h0001, 1, 20'd753};
    // G4 after timeout
    vt[26] = '{510, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[27] = '{510, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[28] = '{510, 4'd5, 1'b1, 16'h0010, 1, 20'd510};
    // G4 after mid-period reset
    vt[29] = '{510, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[30] = '{510, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[31] = '{510, 4'd5, 1'b1, 16'h0010, 1, 20'd510};
    // A4 with en low, then after en rises
    vt[32] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[33] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[34] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[35] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd510};
    vt[36] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[37] = '{455, 4'd0, 1'b0, 16'h0000, 0, 20'd455};
    vt[38] = '{455, 4'd6, 1'b1, 16'h0020, 1, 20'd455};

    bus.en      = 1'b1;
    bus.tone_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 4'd0, 1'b0, 16'h0000);
    chk("reset period", 32'(bus.period), 32'd0);
    chk("reset strobe", 32'(bus.note_strobe), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // first edge only arms the measurement
    bus.tone_in = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("start valid", 32'(bus.valid), 32'd0);
    chk("start period", 32'(bus.period), 32'd0);
    run(0, 25);

    // locked C4, line held low
    repeat (100) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (TO - 20 - SETTLE - 100) @(negedge clk);
    chk_out("pre-timeout", 4'd1, 1'b1, 16'h0001);
    repeat (40) @(negedge clk);
    chk_out("timeout", 4'd0, 1'b0, 16'h0000);
    chk("timeout period", 32'(bus.period), 32'd753);
    bus.tone_in = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("restart period", 32'(bus.period), 32'd753);
    strobes_seen = strobes;
    run(26, 28);

    // reset pulse mid-period while tone is high
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_out("async rst", 4'd0, 1'b0, 16'h0000);
    chk("async rst period", 32'(bus.period), 32'd0);
    chk("async rst strobe", 32'(bus.note_strobe), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // next edge 510 cycles on: a spurious release edge would lock one edge early
    repeat (255) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (255) @(negedge clk);
    bus.tone_in = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk_out("post-rst edge", 4'd0, 1'b0, 16'h0000);
    chk("post-rst period", 32'(bus.period), 32'd0);
    strobes_seen = strobes;
    run(29, 31);

    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    chk_out("en off", 4'd0, 1'b0, 16'h0000);
    run(32, 34);
    bus.en = 1'b1;
    run(35, 38);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
